// File: rtl/key_event_ctrl.sv
// Gesture classifier for one debounced key: turns press/release pulses into
// single, double, long and auto-repeat events behind a one-entry valid/ack register.
module key_event_ctrl #(
  parameter int unsigned N       = 32,
  parameter int unsigned FREQ    = 50,
  parameter int unsigned DBL_MS  = 300,
  parameter int unsigned LONG_MS = 1000,
  parameter int unsigned REP_MS  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       key_release,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       evt_overflow,
  output logic       busy
);

  localparam int unsigned DBL_CYC  = DBL_MS * 1000 * FREQ;
  localparam int unsigned LONG_CYC = LONG_MS * 1000 * FREQ;
  localparam int unsigned REP_CYC  = REP_MS * 1000 * FREQ;

  localparam logic [N-1:0] DBL_LAST  = N'(DBL_CYC - 1);
  localparam logic [N-1:0] LONG_LAST = N'(LONG_CYC - 1);
  localparam logic [N-1:0] REP_LAST  = N'(REP_CYC - 1);

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_SINGLE = 3'd1;
  localparam logic [2:0] CODE_DOUBLE = 3'd2;
  localparam logic [2:0] CODE_LONG   = 3'd3;
  localparam logic [2:0] CODE_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_HOLD
  } state_e;

  state_e       state_q;
  logic [N-1:0] timer_q;
  logic         busy_q;
  logic         evt_valid_q;
  logic [2:0]   evt_code_q;
  logic         evt_overflow_q;

  logic         press_c;
  logic         release_c;
  logic         dbl_hit_c;
  logic         long_hit_c;
  logic         rep_hit_c;
  logic         emit_c;
  logic [2:0]   emit_code_c;

  // A simultaneous press/release pair is not a legal debouncer output; drop both.
  assign press_c   = key_press & ~key_release;
  assign release_c = key_release & ~key_press;

  assign dbl_hit_c  = (timer_q == DBL_LAST);
  assign long_hit_c = (timer_q == LONG_LAST);
  assign rep_hit_c  = (timer_q == REP_LAST);

  // Event decode; key edges take priority over a coincident timeout.
  always_comb begin
    emit_c      = 1'b0;
    emit_code_c = CODE_NONE;
    case (state_q)
      S_PRESS1: begin
        if (!release_c && long_hit_c) begin
          emit_c      = 1'b1;
          emit_code_c = CODE_LONG;
        end
      end
      S_WAIT2: begin
        if (!press_c && dbl_hit_c) begin
          emit_c      = 1'b1;
          emit_code_c = CODE_SINGLE;
        end
      end
      S_PRESS2: begin
        if (release_c) begin
          emit_c      = 1'b1;
          emit_code_c = CODE_DOUBLE;
        end
      end
      S_HOLD: begin
        if (!release_c && rep_hit_c) begin
          emit_c      = 1'b1;
          emit_code_c = CODE_REPEAT;
        end
      end
      default: begin
      end
    endcase
  end

  // Gesture FSM; the timer only runs in states that have a timeout and is
  // cleared on every transition, so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (press_c) begin
            state_q <= S_PRESS1;
            busy_q  <= 1'b1;
          end
        end
        S_PRESS1: begin
          if (release_c) begin
            state_q <= S_WAIT2;
            timer_q <= '0;
          end else if (long_hit_c) begin
            state_q <= S_HOLD;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        S_WAIT2: begin
          if (press_c) begin
            state_q <= S_PRESS2;
            timer_q <= '0;
          end else if (dbl_hit_c) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        S_PRESS2: begin
          timer_q <= '0;
          if (release_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (release_c) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
          end else if (rep_hit_c) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + N'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry event register; a new event beats a coincident ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid_q    <= 1'b0;
      evt_code_q     <= CODE_NONE;
      evt_overflow_q <= 1'b0;
    end else if (emit_c) begin
      evt_valid_q <= 1'b1;
      evt_code_q  <= emit_code_c;
      if (evt_valid_q && !evt_ack) begin
        evt_overflow_q <= 1'b1;
      end
    end else if (evt_ack && evt_valid_q) begin
      evt_valid_q <= 1'b0;
      evt_code_q  <= CODE_NONE;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_code     = evt_code_q;
  assign evt_overflow = evt_overflow_q;
  assign busy         = busy_q;

endmodule
